// File: rtl/seg_carry_adder_pipe.sv
// seg_carry_adder_pipe: two-stage pipelined adder with segmented carry speculation.
//   Approximate mode feeds each segment the carry-out of the segment below, computed
//   with that segment's own carry-in forced to 0. Exact mode uses the true ripple carry.
//   Optional feature macro: SCA_ERR_FLAG_EN adds err_o, set when the result differs from the exact sum.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   valid_i / ready_o     operand handshake (ready_o is combinational from ready_i)
//   input1_i, input2_i    operands A and B (WIDTH bits)
//   mode_i                0 = approximate, 1 = exact (sampled with operands)
//   valid_o / ready_i     result handshake
//   sum_o, carry_o        result sum and carry-out
//   err_o                 approximation error flag (SCA_ERR_FLAG_EN only)
module seg_carry_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] input1_i,
  input  logic [WIDTH-1:0] input2_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
`ifdef SCA_ERR_FLAG_EN
  ,
  output logic             err_o
`endif
);

  localparam int unsigned NSEG = WIDTH / SEG;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic [NSEG-1:0]  lco_q, lco_d;
  logic             mode_q, mode_d;

  // Stage 2 (output) state
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef SCA_ERR_FLAG_EN
  logic             err_q, err_d;
  logic [WIDTH:0]   exact_c;
`endif

  // Stage 2 combinational datapath
  logic [WIDTH:0]   c_chain;
  logic [NSEG-1:0]  cin;
  logic [WIDTH-1:0] sum_c;
  logic             carry_c;

  logic s1_en, s2_en;

  // Pipeline enables; no skid buffer, so ready_o follows ready_i combinationally
  assign s2_en   = ~valid_q | ready_i;
  assign s1_en   = ~s1_valid_q | s2_en;
  assign ready_o = s1_en;

  // Stage 1: capture operands plus per-bit and per-segment carry terms
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    g_d        = g_q;
    p_d        = p_q;
    lco_d      = lco_q;
    mode_d     = mode_q;
    if (s1_en) begin
      s1_valid_d = valid_i;
      a_d        = input1_i;
      b_d        = input2_i;
      g_d        = input1_i & input2_i;
      p_d        = input1_i | input2_i;
      mode_d     = mode_i;
      for (int unsigned k = 0; k < NSEG; k++) begin
        lco_d[k] = 1'(({1'b0, input1_i[k*SEG +: SEG]} + {1'b0, input2_i[k*SEG +: SEG]}) >> SEG);
      end
    end
  end

  // Stage 2 datapath: carry selection and segment sums
  always_comb begin
    // Bit-level lookahead chain gives the true carry into every bit position
    c_chain = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c_chain[i+1] = g_q[i] | (p_q[i] & c_chain[i]);
    end
    cin = '0;
    for (int unsigned k = 1; k < NSEG; k++) begin
      cin[k] = mode_q ? c_chain[k*SEG] : lco_q[k-1];
    end
    sum_c = '0;
    for (int unsigned k = 0; k < NSEG; k++) begin
      sum_c[k*SEG +: SEG] = a_q[k*SEG +: SEG] + b_q[k*SEG +: SEG] + SEG'(cin[k]);
    end
    // Top-segment carry-out for the speculated carry-in: generate | (all-propagate & cin)
    carry_c = mode_q ? c_chain[WIDTH]
                     : (lco_q[NSEG-1] | ((&p_q[WIDTH-1 -: SEG]) & cin[NSEG-1]));
  end

  // Stage 2 output register next-state; holds while stalled
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SCA_ERR_FLAG_EN
    err_d   = err_q;
    exact_c = {1'b0, a_q} + {1'b0, b_q};
`endif
    if (s2_en) begin
      valid_d = s1_valid_q;
      sum_d   = sum_c;
      carry_d = carry_c;
`ifdef SCA_ERR_FLAG_EN
      err_d   = (exact_c != {carry_c, sum_c});
`endif
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      g_q        <= '0;
      p_q        <= '0;
      lco_q      <= '0;
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
`ifdef SCA_ERR_FLAG_EN
      err_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      g_q        <= g_d;
      p_q        <= p_d;
      lco_q      <= lco_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
`ifdef SCA_ERR_FLAG_EN
      err_q      <= err_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
`ifdef SCA_ERR_FLAG_EN
  assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_seg_carry_adder_pipe.sv
// Testbench for seg_carry_adder_pipe (WIDTH=16, SEG=4): vector table, hand-written
// corner sequences and a random phase, all checked through an expected-result queue.
module tb_seg_carry_adder_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [15:0] sum;
    logic        carry;
    logic        err;
  } txn_t;

  logic        clk_i, rst_i, valid_i, ready_o, mode_i, valid_o, ready_i, carry_o;
  logic [15:0] input1_i, input2_i, sum_o;
`ifdef SCA_ERR_FLAG_EN
  logic        err_o;
`endif

  int checks   = 0;
  int failures = 0;
  txn_t sb[$];

  seg_carry_adder_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .input1_i(input1_i),
    .input2_i(input2_i),
    .mode_i  (mode_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o)
`ifdef SCA_ERR_FLAG_EN
    ,
    .err_o   (err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: exact sum, or segment sums fed by the lower segment's zero-carry-in carry-out
  function automatic txn_t model(input logic [15:0] a, input logic [15:0] b, input logic m);
    txn_t        t;
    logic [16:0] ex;
    logic [4:0]  s;
    logic [15:0] as;
    logic        ac, c;
    ex = {1'b0, a} + {1'b0, b};
    c  = 1'b0;
    as = '0;
    ac = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = {1'b0, a[k*4 +: 4]} + {1'b0, b[k*4 +: 4]} + {4'b0, c};
      as[k*4 +: 4] = s[3:0];
      ac = s[4];
      c  = (({1'b0, a[k*4 +: 4]} + {1'b0, b[k*4 +: 4]}) > 5'd15);
    end
    t.a = a; t.b = b; t.mode = m;
    if (m) begin
      t.sum = ex[15:0]; t.carry = ex[16]; t.err = 1'b0;
    end else begin
      t.sum = as; t.carry = ac; t.err = ({ac, as} != ex);
    end
    return t;
  endfunction

  // Output monitor: every valid cycle (including stalled ones) must match the queue head
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_o actual=1 required=0");
      end else begin
        chk("sum_o", 32'(sum_o), 32'(sb[0].sum));
        chk("carry_o", 32'(carry_o), 32'(sb[0].carry));
`ifdef SCA_ERR_FLAG_EN
        chk("err_o", 32'(err_o), 32'(sb[0].err));
`endif
        if (ready_i) void'(sb.pop_front());
      end
    end
  end

  // One cycle: drive at posedge+1, sample ready_o at negedge, return at next posedge+1
  task automatic step(input txn_t t, input logic v, input logic rdy, output logic acc);
    valid_i  = v;
    input1_i = t.a;
    input2_i = t.b;
    mode_i   = t.mode;
    ready_i  = rdy;
    @(negedge clk_i);
    acc = v && ready_o;
    @(posedge clk_i);
    if (acc) sb.push_back(t);
    #1;
  endtask

  task automatic drain();
    txn_t idle;
    logic acc;
    int   n;
    idle = '0;
    n    = 0;
    while (sb.size() != 0 && n < 100) begin
      step(idle, 1'b0, 1'b1, acc);
      n++;
    end
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  txn_t vec[8];
  txn_t stall_items[4];
  txn_t cur;
  logic acc;
  int   idx, cyc;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    //              a        b        m     sum      c     err
    vec[0] = {16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vec[1] = {16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0};
    vec[2] = {16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vec[3] = {16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0};
    vec[4] = {16'hFFFF, 16'h0001, 1'b0, 16'hFF00, 1'b0, 1'b1};
    vec[5] = {16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};
    vec[6] = {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vec[7] = {16'h0FFF, 16'h0001, 1'b0, 16'h0F00, 1'b0, 1'b1};

    rst_i = 1'b1; valid_i = 1'b0; input1_i = '0; input2_i = '0; mode_i = 1'b0; ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_valid_o", 32'(valid_o), 32'd0);
    chk("reset_sum_o", 32'(sum_o), 32'd0);
    chk("reset_carry_o", 32'(carry_o), 32'd0);
    chk("reset_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Latency: valid_o two cycles after the accept cycle
    step(vec[0], 1'b1, 1'b1, acc);
    chk("latency_accept", 32'(acc), 32'd1);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("latency_cycle1_valid_o", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("latency_cycle2_valid_o", 32'(valid_o), 32'd1);
    @(posedge clk_i);
    #1;
    drain();

    // Vector table, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(vec[i], 1'b1, 1'b1, acc);
      chk("table_accept", 32'(acc), 32'd1);
    end
    drain();

    // Back-to-back four with ready_i low for 3 cycles after the first result
    for (int i = 0; i < 4; i++)
      stall_items[i] = model(16'(16'h1357 * (i + 1)), 16'(16'h0F0F + i), i[0]);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      step(stall_items[idx], 1'b1, !(cyc >= 2 && cyc <= 4), acc);
      if (cyc == 2) begin
        chk("stall_accepts_before_ready_low", 32'(idx), 32'd2);
        chk("stall_ready_o_low", 32'(acc), 32'd0);
      end
      if (cyc == 5) chk("stall_ready_o_back", 32'(acc), 32'd1);
      if (acc) idx++;
      cyc++;
    end
    chk("stall_all_accepted", 32'(idx), 32'd4);
    valid_i = 1'b0;
    drain();

    // Alternating mode with identical operands
    for (int i = 0; i < 6; i++) begin
      cur = '0;
      cur.a = 16'h00FF; cur.b = 16'h0001; cur.mode = i[0];
      cur.sum = i[0] ? 16'h0100 : 16'h0000;
      cur.carry = 1'b0;
      cur.err = !i[0];
      step(cur, 1'b1, 1'b1, acc);
      chk("alt_mode_accept", 32'(acc), 32'd1);
    end
    valid_i = 1'b0;
    drain();

    // Random operands, random valid gaps and backpressure
    idx = 0;
    cyc = 0;
    cur = model(16'($urandom), 16'($urandom), 1'($urandom));
    while (idx < 40 && cyc < 600) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step(cur, v, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        idx++;
        if ($urandom_range(0, 1) == 0)
          cur = model(16'($urandom), 16'($urandom), 1'($urandom));
        else
          cur = model(16'($urandom) | 16'h0F0F, 16'($urandom_range(0, 3)), 1'($urandom));
      end
      cyc++;
    end
    chk("random_all_accepted", 32'(idx), 32'd40);
    valid_i = 1'b0;
    drain();

    // Reset mid-stream while valid_o is high
    for (int i = 0; i < 3; i++) step(vec[5 + i], 1'b1, 1'b1, acc);
    valid_i = 1'b0;
    #2;
    chk("midreset_pre_valid_o", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midreset_valid_o", 32'(valid_o), 32'd0);
    chk("midreset_sum_o", 32'(sum_o), 32'd0);
    chk("midreset_carry_o", 32'(carry_o), 32'd0);
    chk("midreset_ready_o", 32'(ready_o), 32'd1);
    sb.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("postreset_ready_o", 32'(ready_o), 32'd1);
    step(vec[3], 1'b1, 1'b1, acc);
    chk("postreset_accept", 32'(acc), 32'd1);
    valid_i = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
